// File: rtl/hazard_stall_unit.sv
// Load-use / memory-wait / branch-flush stall controller for the ID stage.
// Define HAZARD_STALL_CNT_EN to build the saturating stall_cycles counter.
module hazard_stall_unit #(
   parameter int MAX_WAIT = 16,
   parameter int CW       = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [4:0]    IF_ID_Rn,
   input  logic [4:0]    IF_ID_Rm,
   input  logic [4:0]    ID_EX_Rd,
   input  logic          ID_EX_memRead,
   input  logic          branch_taken,
   input  logic          dmem_busy,
   output logic          PCWrite,
   output logic          IF_ID_write,
   output logic          ID_EX_write,
   output logic          EX_MEM_write,
   output logic          ID_EX_bubble,
   output logic          IF_ID_flush,
   output logic          ID_EX_flush,
   output logic          mem_fault,
   output logic [CW-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      S_RUN,
      S_WAIT,
      S_FAULT
   } state_t;

   state_t        r_state;
   state_t        w_nstate;
   logic [CW-1:0] r_wait_cnt;
   logic [CW-1:0] w_nwait;
   logic          r_flush_pend;
   logic          w_npend;
   logic          r_mem_fault;
   logic          w_nfault;

   logic w_load_use;
   logic w_pc;
   logic w_ifid;
   logic w_idex;
   logic w_exmem;
   logic w_bub;
   logic w_iff;
   logic w_idf;

   // XZR is never really written, so a load into it cannot create a hazard
   assign w_load_use = ID_EX_memRead
                     && (ID_EX_Rd != 5'd31)
                     && ((ID_EX_Rd == IF_ID_Rn) || (ID_EX_Rd == IF_ID_Rm));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_RUN;
         r_wait_cnt   <= '0;
         r_flush_pend <= 1'b0;
         r_mem_fault  <= 1'b0;
      end else begin
         r_state      <= w_nstate;
         r_wait_cnt   <= w_nwait;
         r_flush_pend <= w_npend;
         r_mem_fault  <= w_nfault;
      end
   end

   always_comb begin
      w_nstate = r_state;
      w_nwait  = r_wait_cnt;
      w_npend  = r_flush_pend;
      w_nfault = r_mem_fault;
      w_pc     = 1'b1;
      w_ifid   = 1'b1;
      w_idex   = 1'b1;
      w_exmem  = 1'b1;
      w_bub    = 1'b0;
      w_iff    = 1'b0;
      w_idf    = 1'b0;
      unique case (r_state)
         S_RUN: begin
            if (dmem_busy) begin
               w_pc     = 1'b0;
               w_ifid   = 1'b0;
               w_idex   = 1'b0;
               w_exmem  = 1'b0;
               w_nstate = S_WAIT;
               w_nwait  = CW'(1);
               if (branch_taken) w_npend = 1'b1;
            end else if (branch_taken) begin
               w_iff   = 1'b1;
               w_idf   = 1'b1;
               w_npend = 1'b0;
            end else if (w_load_use) begin
               w_pc   = 1'b0;
               w_ifid = 1'b0;
               w_bub  = 1'b1;
            end else if (r_flush_pend) begin
               w_iff   = 1'b1;
               w_idf   = 1'b1;
               w_npend = 1'b0;
            end
         end
         S_WAIT: begin
            w_pc    = 1'b0;
            w_ifid  = 1'b0;
            w_idex  = 1'b0;
            w_exmem = 1'b0;
            if (branch_taken) w_npend = 1'b1;
            if (!dmem_busy) begin
               w_nstate = S_RUN;
               w_nwait  = '0;
            end else if (r_wait_cnt == CW'(MAX_WAIT)) begin
               w_nstate = S_FAULT;
               w_nfault = 1'b1;
            end else begin
               w_nwait = r_wait_cnt + CW'(1);
            end
         end
         S_FAULT: begin
            w_pc     = 1'b0;
            w_ifid   = 1'b0;
            w_idex   = 1'b0;
            w_exmem  = 1'b0;
            w_nfault = 1'b1;
         end
         default: begin
            w_pc     = 1'b0;
            w_ifid   = 1'b0;
            w_idex   = 1'b0;
            w_exmem  = 1'b0;
            w_nstate = S_RUN;
         end
      endcase
   end

   // Every output is held low for the whole time reset is asserted
   assign PCWrite      = reset & w_pc;
   assign IF_ID_write  = reset & w_ifid;
   assign ID_EX_write  = reset & w_idex;
   assign EX_MEM_write = reset & w_exmem;
   assign ID_EX_bubble = reset & w_bub;
   assign IF_ID_flush  = reset & w_iff;
   assign ID_EX_flush  = reset & w_idf;
   assign mem_fault    = reset & r_mem_fault;

`ifdef HAZARD_STALL_CNT_EN
   logic [CW-1:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (!w_pc && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CW'(1);
      end
   end

   assign stall_cycles = r_stall_cnt;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized bench for hazard_stall_unit against a cycle-level reference
// model built from streak/fault/pending bookkeeping.
module tb_hazard_stall_unit;

   localparam int MAXW = 16;
   localparam int CW   = 8;

   logic          clk;
   logic          reset;
   logic [4:0]    IF_ID_Rn;
   logic [4:0]    IF_ID_Rm;
   logic [4:0]    ID_EX_Rd;
   logic          ID_EX_memRead;
   logic          branch_taken;
   logic          dmem_busy;
   logic          PCWrite;
   logic          IF_ID_write;
   logic          ID_EX_write;
   logic          EX_MEM_write;
   logic          ID_EX_bubble;
   logic          IF_ID_flush;
   logic          ID_EX_flush;
   logic          mem_fault;
   logic [CW-1:0] stall_cycles;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: consecutive busy cycles seen, fault latch, flush owed
   int streak;
   bit faulted;
   bit pending;
   int scnt;

   hazard_stall_unit #(.MAX_WAIT(MAXW), .CW(CW)) dut (
      .clk           (clk),
      .reset         (reset),
      .IF_ID_Rn      (IF_ID_Rn),
      .IF_ID_Rm      (IF_ID_Rm),
      .ID_EX_Rd      (ID_EX_Rd),
      .ID_EX_memRead (ID_EX_memRead),
      .branch_taken  (branch_taken),
      .dmem_busy     (dmem_busy),
      .PCWrite       (PCWrite),
      .IF_ID_write   (IF_ID_write),
      .ID_EX_write   (ID_EX_write),
      .EX_MEM_write  (EX_MEM_write),
      .ID_EX_bubble  (ID_EX_bubble),
      .IF_ID_flush   (IF_ID_flush),
      .ID_EX_flush   (ID_EX_flush),
      .mem_fault     (mem_fault),
      .stall_cycles  (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] outs();
      return {PCWrite, IF_ID_write, ID_EX_write, EX_MEM_write,
              ID_EX_bubble, IF_ID_flush, ID_EX_flush, mem_fault};
   endfunction

   function automatic int exp_stall(input int c);
`ifdef HAZARD_STALL_CNT_EN
      return c;
`else
      return 0 * c;
`endif
   endfunction

   function automatic void model_reset();
      streak  = 0;
      faulted = 0;
      pending = 0;
      scnt    = 0;
   endfunction

   task automatic cyc(input string tag, input bit busy, input bit br,
                      input bit mr, input int rd, input int rn, input int rm);
      logic [7:0] e;
      bit lu;
      bit f0;
      @(negedge clk);
      dmem_busy     = busy;
      branch_taken  = br;
      ID_EX_memRead = mr;
      ID_EX_Rd      = 5'(rd);
      IF_ID_Rn      = 5'(rn);
      IF_ID_Rm      = 5'(rm);
      #2;
      lu = mr && rd != 31 && (rd == rn || rd == rm);
      f0 = faulted;
      e  = 8'b1111_0000;
      if (faulted) begin
         e = 8'h00;
      end else if (streak > 0) begin
         e = 8'h00;
         if (br) pending = 1;
         if (!busy) streak = 0;
         else if (streak == MAXW) faulted = 1;
         else streak++;
      end else if (busy) begin
         e      = 8'h00;
         streak = 1;
         if (br) pending = 1;
      end else if (br) begin
         e       = 8'b1111_0110;
         pending = 0;
      end else if (lu) begin
         e = 8'b0011_1000;
      end else if (pending) begin
         e       = 8'b1111_0110;
         pending = 0;
      end
      e[0] = f0;
      check(tag, 32'(outs()), 32'(e));
      check({tag, "_stall"}, 32'(stall_cycles), 32'(exp_stall(scnt)));
      if (!e[7] && scnt < 255) scnt++;
   endtask

   // async reset asserted between edges, then released with idle inputs
   task automatic do_reset(input string tag);
      @(negedge clk);
      #3 reset = 1'b0;
      #1;
      check({tag, "_now"}, 32'(outs()), 32'h0);
      check({tag, "_cnt"}, 32'(stall_cycles), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      check({tag, "_hold"}, 32'(outs()), 32'h0);
      @(negedge clk);
      dmem_busy     = 1'b0;
      branch_taken  = 1'b0;
      ID_EX_memRead = 1'b0;
      reset         = 1'b1;
      #2;
      check({tag, "_rel"}, 32'(outs()), 32'hF0);
   endtask

   function automatic int pick_reg();
      int k;
      k = int'($urandom_range(0, 3));
      if (k == 0) return 3;
      if (k == 1) return 5;
      if (k == 2) return 31;
      return int'($urandom_range(0, 31));
   endfunction

   initial begin
      reset         = 1'b0;
      dmem_busy     = 1'b0;
      branch_taken  = 1'b0;
      ID_EX_memRead = 1'b0;
      ID_EX_Rd      = '0;
      IF_ID_Rn      = '0;
      IF_ID_Rm      = '0;
      model_reset();
      #2;
      check("init_outs", 32'(outs()), 32'h0);
      check("init_cnt", 32'(stall_cycles), 32'h0);
      do_reset("rst0");

      cyc("lu_hit", 0, 0, 1, 3, 3, 7);
      cyc("lu_after", 0, 0, 0, 3, 3, 7);
      cyc("lu_rm", 0, 0, 1, 9, 1, 9);
      cyc("xzr", 0, 0, 1, 31, 0, 31);
      cyc("xzr_rn", 0, 0, 1, 31, 31, 2);

      cyc("bz1", 1, 0, 0, 0, 0, 0);
      cyc("bz2", 1, 1, 0, 0, 0, 0);
      cyc("bz3", 1, 0, 0, 0, 0, 0);
      cyc("bz4", 1, 0, 0, 0, 0, 0);
      cyc("bz_drop", 0, 0, 0, 0, 0, 0);
      cyc("bz_flush", 0, 0, 0, 0, 0, 0);
      cyc("bz_after", 0, 0, 0, 0, 0, 0);

      cyc("br_lu", 0, 1, 1, 4, 4, 4);
      cyc("br_lu_nx", 0, 0, 0, 4, 4, 4);

      for (int i = 0; i < 20; i++) cyc("flt_busy", 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc("flt_hold", 0, 0, 1, 2, 2, 0);
      do_reset("rst_flt");

      cyc("w1", 1, 0, 0, 0, 0, 0);
      cyc("w2", 1, 0, 0, 0, 0, 0);
      cyc("w3", 1, 1, 0, 0, 0, 0);
      do_reset("rst_wait");
      cyc("w_after", 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset("rnd_rst");
         end else begin
            cyc("rnd",
                $urandom_range(0, 9) < 3,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 1) == 1,
                pick_reg(), pick_reg(), pick_reg());
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
